// File: rtl/pwm_freq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_freq_ctrl
// Description : Selectable clock divider, 8-bit PWM period counter and
//               double-buffered freq/duty config with sequenced start/stop.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_freq_ctrl #(
    parameter int DIV_W = 9,
    parameter int DIV0  = 332,
    parameter int DIV1  = 166,
    parameter int DIV2  = 82,
    parameter int DIV3  = 3,
    parameter int TOP   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_freq_sel,
    input  logic [7:0] cfg_duty,
    output logic       tick,
    output logic       period_start,
    output logic       pwm_out,
    output logic       busy
);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_RUN      = 2'd1;
    localparam logic [1:0]       c_STOPPING = 2'd2;
    localparam logic [DIV_W-1:0] c_DIV0     = DIV_W'(DIV0);
    localparam logic [DIV_W-1:0] c_DIV1     = DIV_W'(DIV1);
    localparam logic [DIV_W-1:0] c_DIV2     = DIV_W'(DIV2);
    localparam logic [DIV_W-1:0] c_DIV3     = DIV_W'(DIV3);
    localparam logic [7:0]       c_TOP      = 8'(TOP);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [1:0]       act_sel_q, act_sel_d;
    logic [7:0]       act_duty_q, act_duty_d;
    logic [1:0]       sh_sel_q, sh_sel_d;
    logic [7:0]       sh_duty_q, sh_duty_d;
    logic             pending_q, pending_d;
    logic             period_start_q, period_start_d;
    logic             pwm_out_q, pwm_out_d;

    logic [DIV_W-1:0] w_term;
    logic             w_running;
    logic             w_period_end;
    logic             w_accept;
    logic             w_apply;

    always_comb begin
        w_term = c_DIV0;
        case (act_sel_q)
            2'd0:    w_term = c_DIV0;
            2'd1:    w_term = c_DIV1;
            2'd2:    w_term = c_DIV2;
            default: w_term = c_DIV3;
        endcase
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (en) state_d = c_RUN;
            end
            c_RUN: begin
                if (!en) state_d = c_STOPPING;
            end
            c_STOPPING: begin
                if (en)                state_d = c_RUN;
                else if (w_period_end) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != c_IDLE);
        w_running    = (state_q == c_RUN) || (state_q == c_STOPPING);
        tick         = w_running && (div_cnt_q == w_term);
        w_period_end = tick && (pwm_cnt_q == c_TOP);
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        div_cnt_d = '0;
        pwm_cnt_d = '0;
        if (w_running) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            pwm_cnt_d = pwm_cnt_q;
            if (tick) begin
                pwm_cnt_d = (pwm_cnt_q == c_TOP) ? 8'd0 : pwm_cnt_q + 8'd1;
            end
        end
    end

    // The first RUN cycle counts as a period start, as does every wrap that stays running.
    always_comb begin
        period_start_d = ((state_q == c_IDLE) && en) ||
                         (w_period_end && (state_d != c_IDLE));
        pwm_out_d      = w_running && (pwm_cnt_q < act_duty_q);
    end

    // ------------------------------------------------------ config buffer
    always_comb begin
        cfg_ready = !pending_q;
        w_accept  = cfg_valid && !pending_q;
        w_apply   = pending_q && ((state_q == c_IDLE) || w_period_end);
    end

    // Active settings only change at a boundary, where div_cnt is also zeroed.
    always_comb begin
        sh_sel_d   = sh_sel_q;
        sh_duty_d  = sh_duty_q;
        act_sel_d  = act_sel_q;
        act_duty_d = act_duty_q;
        pending_d  = pending_q;
        if (w_accept) begin
            sh_sel_d  = cfg_freq_sel;
            sh_duty_d = cfg_duty;
            pending_d = 1'b1;
        end
        if (w_apply) begin
            act_sel_d  = sh_sel_q;
            act_duty_d = sh_duty_q;
            pending_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            act_sel_q      <= '0;
            act_duty_q     <= '0;
            sh_sel_q       <= '0;
            sh_duty_q      <= '0;
            pending_q      <= 1'b0;
            period_start_q <= 1'b0;
            pwm_out_q      <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            act_sel_q      <= act_sel_d;
            act_duty_q     <= act_duty_d;
            sh_sel_q       <= sh_sel_d;
            sh_duty_q      <= sh_duty_d;
            pending_q      <= pending_d;
            period_start_q <= period_start_d;
            pwm_out_q      <= pwm_out_d;
        end
    end

    assign period_start = period_start_q;
    assign pwm_out      = pwm_out_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_freq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_freq_ctrl
// Description : Directed self-checking bench for pwm_freq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_freq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_freq_sel = 2'd0;
    logic [7:0] cfg_duty = 8'd0;
    logic       tick;
    logic       period_start;
    logic       pwm_out;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hi_cnt = 0;
    int tick_cnt = 0;
    int ps_cnt = 0;
    int last_tick = 0;
    int last_iv = 0;
    int n = 0;

    pwm_freq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_freq_sel (cfg_freq_sel),
        .cfg_duty     (cfg_duty),
        .tick         (tick),
        .period_start (period_start),
        .pwm_out      (pwm_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each step lands on a falling edge, where outputs are stable.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (pwm_out === 1'b1) hi_cnt++;
        if (period_start === 1'b1) ps_cnt++;
        if (tick === 1'b1) begin
            tick_cnt++;
            last_iv   = cyc - last_tick;
            last_tick = cyc;
        end
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic clr();
        hi_cnt   = 0;
        tick_cnt = 0;
        ps_cnt   = 0;
    endtask

    task automatic wait_tick(output int nn);
        nn = 0;
        do begin
            step();
            nn++;
        end while (tick !== 1'b1 && nn < 1000);
    endtask

    task automatic cfg_idle(input logic [1:0] sel, input logic [7:0] duty);
        cfg_valid    = 1'b1;
        cfg_freq_sel = sel;
        cfg_duty     = duty;
        chk("cfg_idle_ready_before", 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        chk("cfg_idle_ready_pending", 32'(cfg_ready), 0);
        step();
        chk("cfg_idle_ready_after", 32'(cfg_ready), 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // Defaults are sel=0 (333-clk tick) and duty=0 (output never high).
    task automatic defaults_check(input string tag);
        en = 1'b1;
        step();
        chk({tag, "_first_ps"}, 32'(period_start), 1);
        chk({tag, "_first_busy"}, 32'(busy), 1);
        chk({tag, "_first_tick"}, 32'(tick), 0);
        clr();
        n = 1;
        while (tick !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk({tag, "_tick1_clk"}, 32'(n), 333);
        wait_tick(n);
        chk({tag, "_tick2_clk"}, 32'(n), 333);
        chk({tag, "_pwm_high_cnt"}, 32'(hi_cnt), 0);
        chk({tag, "_ps_cnt"}, 32'(ps_cnt), 0);
    endtask

    initial begin
        // Reset state
        step();
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_period_start", 32'(period_start), 0);
        chk("rst_pwm_out", 32'(pwm_out), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 0);

        // Run with defaults
        defaults_check("dflt");
        do_reset();

        // sel=3 duty=64 configured while idle
        cfg_idle(2'd3, 8'd64);
        en = 1'b1;
        step();
        chk("s3_first_ps", 32'(period_start), 1);
        chk("s3_first_pwm", 32'(pwm_out), 0);
        clr();
        run(256);
        chk("s3_pwm_last_high", 32'(pwm_out), 1);
        step();
        chk("s3_pwm_first_low", 32'(pwm_out), 0);
        run(767);
        chk("s3_hi_cnt", 32'(hi_cnt), 256);
        chk("s3_tick_cnt", 32'(tick_cnt), 256);
        chk("s3_ps_cnt", 32'(ps_cnt), 1);
        chk("s3_tick_iv", 32'(last_iv), 4);

        // Mid-period duty change to 192, with a second offer stalled
        clr();
        run(400);
        cfg_valid    = 1'b1;
        cfg_freq_sel = 2'd3;
        cfg_duty     = 8'd192;
        chk("upd_ready_before", 32'(cfg_ready), 1);
        step();
        chk("upd_ready_pending", 32'(cfg_ready), 0);
        cfg_duty = 8'd8;
        run(622);
        chk("upd_period_end_tick", 32'(tick), 1);
        chk("upd_ready_at_end", 32'(cfg_ready), 0);
        step();
        chk("upd_ready_after", 32'(cfg_ready), 1);
        chk("upd_ps_after", 32'(period_start), 1);
        cfg_valid = 1'b0;
        chk("upd_old_duty_hi", 32'(hi_cnt), 256);
        clr();
        run(1024);
        chk("upd_new_duty_hi", 32'(hi_cnt), 768);
        clr();
        run(1024);
        chk("upd_second_offer_ignored_hi", 32'(hi_cnt), 768);

        // Stop request at pwm_cnt=10 completes the period
        clr();
        run(40);
        en = 1'b0;
        run(983);
        chk("stop_busy_last", 32'(busy), 1);
        chk("stop_tick_last", 32'(tick), 1);
        step();
        chk("stop_busy_idle", 32'(busy), 0);
        chk("stop_pwm_idle", 32'(pwm_out), 0);
        chk("stop_ps_idle", 32'(period_start), 0);
        chk("stop_hi_cnt", 32'(hi_cnt), 768);
        run(3);
        chk("stop_tick_idle", 32'(tick), 0);

        // Stop then re-enable at pwm_cnt=100 keeps running
        en = 1'b1;
        step();
        chk("rearm_first_ps", 32'(period_start), 1);
        clr();
        run(40);
        en = 1'b0;
        run(360);
        en = 1'b1;
        run(623);
        step();
        chk("rearm_busy", 32'(busy), 1);
        chk("rearm_ps", 32'(period_start), 1);
        chk("rearm_hi_cnt", 32'(hi_cnt), 768);

        // Asynchronous reset during the high phase
        run(10);
        chk("areset_pre_pwm", 32'(pwm_out), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("areset_pwm", 32'(pwm_out), 0);
        chk("areset_tick", 32'(tick), 0);
        chk("areset_busy", 32'(busy), 0);
        chk("areset_ready", 32'(cfg_ready), 1);
        chk("areset_ps", 32'(period_start), 0);
        en = 1'b0;
        step();
        rst = 1'b1;
        defaults_check("post_rst");
        do_reset();

        // Divider switch 2 -> 3 at a period boundary
        cfg_idle(2'd2, 8'd0);
        en = 1'b1;
        step();
        run(99);
        cfg_valid    = 1'b1;
        cfg_freq_sel = 2'd3;
        cfg_duty     = 8'd0;
        chk("sw_ready_before", 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        chk("sw_ready_pending", 32'(cfg_ready), 0);
        run(21147);
        chk("sw_end_tick", 32'(tick), 1);
        chk("sw_old_iv", 32'(last_iv), 83);
        chk("sw_ready_at_end", 32'(cfg_ready), 0);
        clr();
        wait_tick(n);
        chk("sw_first_new_tick", 32'(n), 4);
        chk("sw_ps_cnt", 32'(ps_cnt), 1);
        chk("sw_ready_after", 32'(cfg_ready), 1);
        wait_tick(n);
        chk("sw_second_new_tick", 32'(n), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
